// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE  = 2'd0,
    BOUNCE1 = 2'd1,
    BOUNCE2 = 2'd2
  } filt_state_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // Increment v, holding at the all-ones value of a w-bit word (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= lim) ? lim : v + 64'd1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-FF synchroniser, bounce filter and software lock stage.
//   filter state | meaning
//   STABLE       | s matches debounced value
//   BOUNCE1      | s differs from value, timing toward commit
//   BOUNCE2      | s returned to value, timing toward quiet
//   lock state   | meaning
//   UNLOCKED     | outputs track commits
//   LOCKED       | event latched, waiting for unlock
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int POS_WIDTH   = 32,
  parameter int TIMER_WIDTH = 32,
  parameter int CYCLE_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sig_in,
  input  logic                   invert,
  input  logic                   rise_en,
  input  logic                   fall_en,
  input  logic                   unlock,
  input  logic [POS_WIDTH-1:0]   pos_in,
  input  logic [TIMER_WIDTH-1:0] timeout,
  output logic                   sig_out,
  output logic                   sig_changed,
  output logic [POS_WIDTH-1:0]   pos_out,
  output logic [TIMER_WIDTH-1:0] max_bounce,
  output logic [CYCLE_WIDTH-1:0] cycles
);

  logic                   sync1, sync2, value, commit;
  logic [TIMER_WIDTH-1:0] timer;
  logic [POS_WIDTH-1:0]   start_pos;
  filt_state_t            filt_state, filt_nxt;
  lock_state_t            lock_state, lock_nxt;

  logic                   s, edge_en, record;
  logic                   value_nxt, commit_nxt, sig_out_nxt, chg_nxt;
  logic [TIMER_WIDTH-1:0] timer_nxt, timer_inc, mb_nxt;
  logic [POS_WIDTH-1:0]   start_pos_nxt, pos_nxt;
  logic [CYCLE_WIDTH-1:0] cyc_nxt, cyc_inc;

  assign s         = sync2 ^ invert;
  assign edge_en   = value ? rise_en : fall_en;
  assign timer_inc = TIMER_WIDTH'(sat_inc(64'(timer), TIMER_WIDTH));
  assign cyc_inc   = CYCLE_WIDTH'(sat_inc(64'(cycles), CYCLE_WIDTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      filt_state  <= STABLE;
      value       <= 1'b0;
      timer       <= '0;
      start_pos   <= '0;
      max_bounce  <= '0;
      commit      <= 1'b0;
      lock_state  <= UNLOCKED;
      sig_out     <= 1'b0;
      sig_changed <= 1'b0;
      pos_out     <= '0;
      cycles      <= '0;
    end else begin
      sync1       <= sig_in;
      sync2       <= sync1;
      filt_state  <= filt_nxt;
      value       <= value_nxt;
      timer       <= timer_nxt;
      start_pos   <= start_pos_nxt;
      max_bounce  <= mb_nxt;
      commit      <= commit_nxt;
      lock_state  <= lock_nxt;
      sig_out     <= sig_out_nxt;
      sig_changed <= chg_nxt;
      pos_out     <= pos_nxt;
      cycles      <= cyc_nxt;
    end
  end

  always_comb begin
    filt_nxt = filt_state;
    case (filt_state)
      STABLE:  if (s != value) filt_nxt = BOUNCE1;
      BOUNCE1: if (s == value) filt_nxt = BOUNCE2;
               else if (timer > timeout) filt_nxt = STABLE;
      BOUNCE2: if (s != value) filt_nxt = BOUNCE1;
               else if (timer > timeout) filt_nxt = STABLE;
      default: filt_nxt = STABLE;
    endcase
  end

  // Timer comparison uses the pre-increment value, so a clean step commits T+5 edges after it arrives.
  always_comb begin
    timer_nxt     = timer;
    value_nxt     = value;
    start_pos_nxt = start_pos;
    commit_nxt    = 1'b0;
    record        = 1'b0;
    case (filt_state)
      STABLE: begin
        if (s != value) begin
          timer_nxt     = '0;
          start_pos_nxt = pos_in;
        end
      end
      BOUNCE1: begin
        if (s == value) begin
          timer_nxt = '0;
          record    = 1'b1;
        end else begin
          timer_nxt = timer_inc;
          if (timer > timeout) begin
            value_nxt  = s;
            commit_nxt = 1'b1;
          end
        end
      end
      BOUNCE2: begin
        if (s != value) begin
          timer_nxt = '0;
          record    = 1'b1;
        end else begin
          timer_nxt = timer_inc;
        end
      end
      default: timer_nxt = '0;
    endcase

    mb_nxt = max_bounce;
    if (record) begin
      if (timer > max_bounce) mb_nxt = timer;
    end else if (unlock) begin
      mb_nxt = '0;
    end
  end

  always_comb begin
    lock_nxt = lock_state;
    case (lock_state)
      UNLOCKED: if (commit && edge_en) lock_nxt = LOCKED;
      LOCKED:   if (unlock) lock_nxt = UNLOCKED;
      default:  lock_nxt = UNLOCKED;
    endcase
  end

  // An unlock coinciding with a commit releases the lock and drops that commit from the count.
  always_comb begin
    sig_out_nxt = sig_out;
    chg_nxt     = sig_changed;
    pos_nxt     = pos_out;
    cyc_nxt     = cycles;
    case (lock_state)
      UNLOCKED: begin
        if (commit) begin
          sig_out_nxt = value;
          cyc_nxt     = cyc_inc;
          if (edge_en) begin
            pos_nxt = start_pos;
            chg_nxt = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (unlock) begin
          chg_nxt     = 1'b0;
          sig_out_nxt = value;
        end else if (commit) begin
          cyc_nxt = cyc_inc;
        end
      end
      default: chg_nxt = 1'b0;
    endcase
  end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel endstop debouncer: CHANNELS independent debounce_chan instances
// sharing a timeout, plus a registered OR of the latched event flags.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int POS_WIDTH   = 32,
  parameter int TIMER_WIDTH = 32,
  parameter int CYCLE_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [CHANNELS-1:0]             sig_in,
  input  logic [CHANNELS-1:0]             invert,
  input  logic [CHANNELS-1:0]             rise_en,
  input  logic [CHANNELS-1:0]             fall_en,
  input  logic [CHANNELS-1:0]             unlock,
  input  logic [CHANNELS*POS_WIDTH-1:0]   pos_in,
  input  logic [TIMER_WIDTH-1:0]          timeout,
  output logic [CHANNELS-1:0]             sig_out,
  output logic [CHANNELS-1:0]             sig_changed,
  output logic                            any_changed,
  output logic [CHANNELS*POS_WIDTH-1:0]   pos_out,
  output logic [CHANNELS*TIMER_WIDTH-1:0] max_bounce,
  output logic [CHANNELS*CYCLE_WIDTH-1:0] cycles
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_chan #(
      .POS_WIDTH  (POS_WIDTH),
      .TIMER_WIDTH(TIMER_WIDTH),
      .CYCLE_WIDTH(CYCLE_WIDTH)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .sig_in     (sig_in[i]),
      .invert     (invert[i]),
      .rise_en    (rise_en[i]),
      .fall_en    (fall_en[i]),
      .unlock     (unlock[i]),
      .pos_in     (pos_in[i*POS_WIDTH +: POS_WIDTH]),
      .timeout    (timeout),
      .sig_out    (sig_out[i]),
      .sig_changed(sig_changed[i]),
      .pos_out    (pos_out[i*POS_WIDTH +: POS_WIDTH]),
      .max_bounce (max_bounce[i*TIMER_WIDTH +: TIMER_WIDTH]),
      .cycles     (cycles[i*CYCLE_WIDTH +: CYCLE_WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) any_changed <= 1'b0;
    else       any_changed <= |sig_changed;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: a per-edge vector table for the clean-step
// latency, then hand-written sequences for bounce, polarity, lock, saturation and reset.
module tb_debounce_multi;

  logic         clk, reset;
  logic [3:0]   sig_in, invert, rise_en, fall_en, unlock;
  logic [127:0] pos_in;
  logic [31:0]  timeout;
  logic [3:0]   sig_out, sig_changed;
  logic         any_changed;
  logic [127:0] pos_out, max_bounce;
  logic [31:0]  cycles;

  int checks = 0;
  int errors = 0;

  debounce_multi #(
    .CHANNELS(4), .POS_WIDTH(32), .TIMER_WIDTH(32), .CYCLE_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .invert(invert),
    .rise_en(rise_en), .fall_en(fall_en), .unlock(unlock), .pos_in(pos_in),
    .timeout(timeout), .sig_out(sig_out), .sig_changed(sig_changed),
    .any_changed(any_changed), .pos_out(pos_out), .max_bounce(max_bounce),
    .cycles(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sig;
    logic [31:0] pos0;
    logic [3:0]  e_out;
    logic [3:0]  e_chg;
    logic        e_any;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the falling edge after each rise.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    // Edge k = k-th rising edge after reset release; ch0 rises at edge 1, T=3.
    tbl[0] = '{4'b0101, 32'd50,  4'b0000, 4'b0000, 1'b0};
    tbl[1] = '{4'b0101, 32'd50,  4'b0000, 4'b0000, 1'b0};
    tbl[2] = '{4'b0101, 32'd100, 4'b0000, 4'b0000, 1'b0};
    tbl[3] = '{4'b0101, 32'd150, 4'b0000, 4'b0000, 1'b0};
    tbl[4] = '{4'b0101, 32'd150, 4'b0000, 4'b0000, 1'b0};
    tbl[5] = '{4'b0101, 32'd150, 4'b0000, 4'b0000, 1'b0};
    tbl[6] = '{4'b0101, 32'd150, 4'b0000, 4'b0000, 1'b0};
    tbl[7] = '{4'b0101, 32'd150, 4'b0000, 4'b0000, 1'b0};
    tbl[8] = '{4'b0101, 32'd150, 4'b0001, 4'b0001, 1'b0};
    tbl[9] = '{4'b0101, 32'd150, 4'b0001, 4'b0001, 1'b1};

    reset   = 1'b1;
    sig_in  = 4'b0100;
    invert  = 4'b0100;
    rise_en = 4'b1011;
    fall_en = 4'b0100;
    unlock  = 4'b0000;
    pos_in  = '0;
    timeout = 32'd3;
    step(3);
    check("rst sig_out", sig_out, 0);
    check("rst sig_changed", sig_changed, 0);
    check("rst any_changed", any_changed, 0);
    check("rst pos_out", pos_out, 0);
    check("rst max_bounce", max_bounce, 0);
    check("rst cycles", cycles, 0);
    reset = 1'b0;

    // Clean rise on ch0, T=3: event at edge 9, any_changed at edge 10.
    for (int k = 0; k < 10; k++) begin
      sig_in       = tbl[k].sig;
      pos_in[31:0] = tbl[k].pos0;
      step(1);
      check($sformatf("t1 e%0d sig_out", k + 1), sig_out, tbl[k].e_out);
      check($sformatf("t1 e%0d sig_changed", k + 1), sig_changed, tbl[k].e_chg);
      check($sformatf("t1 e%0d any_changed", k + 1), any_changed, tbl[k].e_any);
    end
    check("t1 pos_out0", pos_out[31:0], 100);
    check("t1 cycles0", cycles[7:0], 1);

    // ch1, T=5: high 2, low 5 (BOUNCE2 timer reaches 4), then high steady.
    timeout       = 32'd5;
    pos_in[63:32] = 32'd200;
    sig_in[1]     = 1'b1;
    step(2);
    sig_in[1] = 1'b0;
    step(5);
    pos_in[63:32] = 32'd260;
    sig_in[1]     = 1'b1;
    step(20);
    check("t2 sig_changed1", sig_changed[1], 1);
    check("t2 sig_out1", sig_out[1], 1);
    check("t2 pos_out1", pos_out[63:32], 200);
    check("t2 max_bounce1", max_bounce[63:32], 4);
    check("t2 cycles1", cycles[15:8], 1);

    // ch2 active-low, fall_en only: raw low is an s rise (no lock), raw high locks.
    timeout   = 32'd4;
    sig_in[2] = 1'b0;
    step(15);
    check("t3a sig_out2", sig_out[2], 1);
    check("t3a sig_changed2", sig_changed[2], 0);
    check("t3a cycles2", cycles[23:16], 1);
    sig_in[2] = 1'b1;
    step(15);
    check("t3b sig_changed2", sig_changed[2], 1);
    check("t3b sig_out2", sig_out[2], 0);
    check("t3b cycles2", cycles[23:16], 2);

    // ch0 locked: a clean fall, then a bouncy rise (max_bounce 2), both counted, outputs frozen.
    timeout      = 32'd2;
    pos_in[31:0] = 32'd777;
    sig_in[0]    = 1'b0;
    step(12);
    check("t4a cycles0", cycles[7:0], 2);
    check("t4a sig_out0", sig_out[0], 1);
    check("t4a pos_out0", pos_out[31:0], 100);
    check("t4a sig_changed0", sig_changed[0], 1);
    sig_in[0] = 1'b1;
    step(3);
    sig_in[0] = 1'b0;
    step(2);
    sig_in[0] = 1'b1;
    step(14);
    check("t4b cycles0", cycles[7:0], 3);
    check("t4b max_bounce0", max_bounce[31:0], 2);
    check("t4b sig_out0", sig_out[0], 1);
    check("t4b pos_out0", pos_out[31:0], 100);
    // Third commit reaches the lock stage at edge T+6=8; unlock there wins.
    sig_in[0] = 1'b0;
    step(7);
    unlock[0] = 1'b1;
    step(1);
    unlock[0] = 1'b0;
    check("t4c sig_changed0", sig_changed[0], 0);
    check("t4c sig_out0", sig_out[0], 0);
    check("t4c cycles0", cycles[7:0], 3);
    check("t4c max_bounce0", max_bounce[31:0], 0);
    step(3);
    check("t4d cycles0", cycles[7:0], 3);
    check("t4d any_changed", any_changed, 1);

    // ch3, T=0: first rise locks, then 300 locked commits saturate the counter.
    timeout = 32'd0;
    for (int k = 0; k < 301; k++) begin
      sig_in[3] = ~sig_in[3];
      step(8);
    end
    check("t5 cycles3", cycles[31:24], 255);
    check("t5 sig_changed3", sig_changed[3], 1);
    check("t5 sig_out3", sig_out[3], 1);

    // Reset with ch0 mid-BOUNCE1 and ch1..3 locked; fresh rises then lock at edge T+6=10.
    timeout   = 32'd4;
    sig_in[0] = 1'b1;
    step(5);
    reset = 1'b1;
    step(1);
    check("t6 rst sig_out", sig_out, 0);
    check("t6 rst sig_changed", sig_changed, 0);
    check("t6 rst any_changed", any_changed, 0);
    check("t6 rst pos_out", pos_out, 0);
    check("t6 rst max_bounce", max_bounce, 0);
    check("t6 rst cycles", cycles, 0);
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (k < 10) begin
        check($sformatf("t6 e%0d sig_changed", k), sig_changed, 4'b0000);
        check($sformatf("t6 e%0d cycles", k), cycles, 0);
      end else begin
        check("t6 e10 sig_changed", sig_changed, 4'b1011);
        check("t6 e10 sig_out", sig_out, 4'b1011);
      end
    end
    step(1);
    check("t6 e11 any_changed", any_changed, 1);
    check("t6 e11 cycles", cycles, 32'h01000101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
